// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares one SPI config flash between the DSP and CPU SPI masters.
//
// Ports:
//   sysclk, reset_INV              UFM oscillator clock, async active-low reset
//   dsp_clk/mosi/cs_INV, dsp_miso  DSP SPI master (raw, async to sysclk)
//   cpu_clk/mosi/cs_INV, cpu_miso  CPU SPI master (raw, async to sysclk)
//   flash_clk/mosi/cs_INV          to the flash; flash_miso from the flash
//   dsp_grant, cpu_grant           registered ownership for software polling
//   timeout                        one-cycle pulse on forced release
//
// Optional feature: define SPI_FLASH_ARB_TIMEOUT_EN to force release of an owner
// after TIMEOUT_CYCLES sysclk cycles; otherwise timeout is tied low.
module spi_flash_arbiter #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic sysclk,
    input  logic reset_INV,
    input  logic dsp_clk,
    input  logic dsp_mosi,
    input  logic dsp_cs_INV,
    output logic dsp_miso,
    input  logic cpu_clk,
    input  logic cpu_mosi,
    input  logic cpu_cs_INV,
    output logic cpu_miso,
    output logic flash_clk,
    output logic flash_mosi,
    output logic flash_cs_INV,
    input  logic flash_miso,
    output logic dsp_grant,
    output logic cpu_grant,
    output logic timeout
);

    typedef enum logic [1:0] {IDLE, GRANT_DSP, GRANT_CPU, GAP} state_t;

    localparam logic OWN_DSP = 1'b0;
    localparam logic OWN_CPU = 1'b1;
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("spi_flash_arbiter: GAP_CYCLES or TIMEOUT_CYCLES out of range");
    end

    state_t     state_q, state_d;
    logic [1:0] dsp_sync_q, cpu_sync_q;
    logic       dsp_stale_q, dsp_stale_d;
    logic       cpu_stale_q, cpu_stale_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       dsp_grant_q, cpu_grant_q;
    logic       dsp_req, cpu_req;
    logic       dsp_fall, cpu_fall;
    logic       own_dsp, own_cpu;

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Index 1 is the synchronized CS; a fall is seen one edge early (stage 0 low,
    // stage 1 still high) so the stale bit lands on the same edge the request would.
    assign dsp_fall = dsp_sync_q[1] & ~dsp_sync_q[0];
    assign cpu_fall = cpu_sync_q[1] & ~cpu_sync_q[0];
    assign dsp_req  = ~dsp_sync_q[1] & ~dsp_stale_q;
    assign cpu_req  = ~cpu_sync_q[1] & ~cpu_stale_q;

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        last_owner_d = last_owner_q;
        dsp_stale_d  = (dsp_fall & (state_q == GRANT_CPU || state_q == GAP)) | (dsp_stale_q & ~dsp_sync_q[1]);
        cpu_stale_d  = (cpu_fall & (state_q == GRANT_DSP || state_q == GAP)) | (cpu_stale_q & ~cpu_sync_q[1]);
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
        timeout_d    = 1'b0;
        tmo_cnt_d    = (state_q == GRANT_DSP || state_q == GRANT_CPU) ? tmo_cnt_q + 16'd1 : 16'd0;
`endif
        case (state_q)
            IDLE: begin
                if (dsp_req && (!cpu_req || last_owner_q == OWN_CPU)) state_d = GRANT_DSP;
                else if (cpu_req) state_d = GRANT_CPU;
            end
            GRANT_DSP: begin
                if (dsp_sync_q[1]) begin
                    state_d      = GAP;
                    gap_cnt_d    = GAP_LOAD;
                    last_owner_d = OWN_DSP;
                end
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d      = GAP;
                    gap_cnt_d    = GAP_LOAD;
                    last_owner_d = OWN_DSP;
                    dsp_stale_d  = 1'b1;
                    timeout_d    = 1'b1;
                end
`endif
            end
            GRANT_CPU: begin
                if (cpu_sync_q[1]) begin
                    state_d      = GAP;
                    gap_cnt_d    = GAP_LOAD;
                    last_owner_d = OWN_CPU;
                end
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d      = GAP;
                    gap_cnt_d    = GAP_LOAD;
                    last_owner_d = OWN_CPU;
                    cpu_stale_d  = 1'b1;
                    timeout_d    = 1'b1;
                end
`endif
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q == 8'd0) begin
                    state_d   = IDLE;
                    gap_cnt_d = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state_q      <= IDLE;
            dsp_sync_q   <= 2'b11;
            cpu_sync_q   <= 2'b11;
            dsp_stale_q  <= 1'b0;
            cpu_stale_q  <= 1'b0;
            last_owner_q <= OWN_CPU;
            gap_cnt_q    <= 8'd0;
            dsp_grant_q  <= 1'b0;
            cpu_grant_q  <= 1'b0;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
            tmo_cnt_q    <= 16'd0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dsp_sync_q   <= {dsp_sync_q[0], dsp_cs_INV};
            cpu_sync_q   <= {cpu_sync_q[0], cpu_cs_INV};
            dsp_stale_q  <= dsp_stale_d;
            cpu_stale_q  <= cpu_stale_d;
            last_owner_q <= last_owner_d;
            gap_cnt_q    <= gap_cnt_d;
            dsp_grant_q  <= (state_d == GRANT_DSP);
            cpu_grant_q  <= (state_d == GRANT_CPU);
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    // The registered state is the owner select; SPI data goes straight through the mux,
    // so an owner's raw CS deselects the flash without waiting for sysclk.
    assign own_dsp      = (state_q == GRANT_DSP);
    assign own_cpu      = (state_q == GRANT_CPU);
    assign flash_clk    = own_dsp ? dsp_clk    : own_cpu ? cpu_clk    : 1'b0;
    assign flash_mosi   = own_dsp ? dsp_mosi   : own_cpu ? cpu_mosi   : 1'b0;
    assign flash_cs_INV = own_dsp ? dsp_cs_INV : own_cpu ? cpu_cs_INV : 1'b1;
    assign dsp_miso     = own_dsp & flash_miso;
    assign cpu_miso     = own_cpu & flash_miso;
    assign dsp_grant    = dsp_grant_q;
    assign cpu_grant    = cpu_grant_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: directed self-checking bench for spi_flash_arbiter.
module tb_spi_flash_arbiter;

    logic sysclk = 1'b0;
    logic reset_INV = 1'b1;
    logic dsp_clk = 1'b0, dsp_mosi = 1'b0, dsp_cs_INV = 1'b1, dsp_miso;
    logic cpu_clk = 1'b0, cpu_mosi = 1'b0, cpu_cs_INV = 1'b1, cpu_miso;
    logic flash_clk, flash_mosi, flash_cs_INV;
    logic flash_miso = 1'b0;
    logic dsp_grant, cpu_grant, timeout;
    int   n_tests = 0;
    int   n_fail = 0;

    spi_flash_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .sysclk(sysclk), .reset_INV(reset_INV),
        .dsp_clk(dsp_clk), .dsp_mosi(dsp_mosi), .dsp_cs_INV(dsp_cs_INV), .dsp_miso(dsp_miso),
        .cpu_clk(cpu_clk), .cpu_mosi(cpu_mosi), .cpu_cs_INV(cpu_cs_INV), .cpu_miso(cpu_miso),
        .flash_clk(flash_clk), .flash_mosi(flash_mosi), .flash_cs_INV(flash_cs_INV),
        .flash_miso(flash_miso), .dsp_grant(dsp_grant), .cpu_grant(cpu_grant), .timeout(timeout)
    );

    always #10 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic do_reset();
        #3 reset_INV = 1'b0;
        tick(2);
        reset_INV = 1'b1;
        tick(1);
    endtask

    initial begin
        logic [7:0] byte_out;
        logic [7:0] cap;
        logic [7:0] miso_pat;
        int pulses;
        byte_out = 8'hAB;
        miso_pat = 8'h5C;

        // Reset values
        #5 reset_INV = 1'b0;
        flash_miso = 1'b1;
        #2;
        check("rst_cs", flash_cs_INV, 1);
        check("rst_clk", flash_clk, 0);
        check("rst_mosi", flash_mosi, 0);
        check("rst_dgnt", dsp_grant, 0);
        check("rst_cgnt", cpu_grant, 0);
        check("rst_dmiso", dsp_miso, 0);
        check("rst_cmiso", cpu_miso, 0);
        check("rst_tmo", timeout, 0);
        tick(2);
        reset_INV = 1'b1;
        tick(1);

        // DSP alone: grant on the 3rd edge, byte passes through bit-exact
        dsp_cs_INV = 1'b0;
        tick(2);
        check("dsp_gnt_e2", dsp_grant, 0);
        tick(1);
        check("dsp_gnt_e3", dsp_grant, 1);
        check("dsp_cs_route", flash_cs_INV, 0);
        cpu_clk = 1'b1;
        cap = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            dsp_mosi = byte_out[b];
            flash_miso = miso_pat[b];
            #2 dsp_clk = 1'b1;
            #1 cap = {cap[6:0], flash_mosi};
            check("dsp_sck", flash_clk, 1);
            check("dsp_miso_echo", dsp_miso, miso_pat[b]);
            check("cpu_miso_zero", cpu_miso, 0);
            #2 dsp_clk = 1'b0;
        end
        check("dsp_byte", cap, 8'hAB);
        cpu_clk = 1'b0;
        tick(1);
        dsp_cs_INV = 1'b1;
        #1 check("dsp_cs_raw_rel", flash_cs_INV, 1);
        tick(2);
        check("dsp_rel_e2", dsp_grant, 1);
        tick(1);
        check("dsp_rel_e3", dsp_grant, 0);
        tick(8);

        // Tie after reset: DSP first, CPU after a 4-cycle gap
        do_reset();
        dsp_cs_INV = 1'b0;
        cpu_cs_INV = 1'b0;
        tick(3);
        check("tie_dgnt", dsp_grant, 1);
        check("tie_cgnt", cpu_grant, 0);
        dsp_cs_INV = 1'b1;
        tick(3);
        check("tie_gap_dgnt", dsp_grant, 0);
        check("tie_gap_cs", flash_cs_INV, 1);
        tick(4);
        check("tie_gap_end", cpu_grant, 0);
        tick(1);
        check("tie_cpu_gnt", cpu_grant, 1);
        check("tie_cpu_cs", flash_cs_INV, 0);
        cpu_cs_INV = 1'b1;
        tick(10);
        check("tie_cpu_rel", cpu_grant, 0);

        // Stale: CPU CS falls while DSP owns
        dsp_cs_INV = 1'b0;
        tick(3);
        check("st_dgnt", dsp_grant, 1);
        cpu_cs_INV = 1'b0;
        tick(5);
        check("st_cgnt_busy", cpu_grant, 0);
        dsp_cs_INV = 1'b1;
        tick(12);
        check("st_dsp_rel", dsp_grant, 0);
        check("st_cpu_not_gnt", cpu_grant, 0);
        cpu_cs_INV = 1'b1;
        tick(4);
        cpu_cs_INV = 1'b0;
        tick(3);
        check("st_cpu_retry", cpu_grant, 1);

        // Reset mid-byte during CPU ownership takes effect without a clock edge
        cpu_mosi = 1'b1;
        cpu_clk = 1'b1;
        #1 check("mid_clk", flash_clk, 1);
        #1 reset_INV = 1'b0;
        #1;
        check("mid_rst_cs", flash_cs_INV, 1);
        check("mid_rst_clk", flash_clk, 0);
        check("mid_rst_cgnt", cpu_grant, 0);
        cpu_clk = 1'b0;
        cpu_mosi = 1'b0;
        cpu_cs_INV = 1'b1;
        tick(2);
        reset_INV = 1'b1;
        tick(1);

        // Long hold: forced release only when the timeout feature is built in
        dsp_cs_INV = 1'b0;
        tick(3);
        check("to_dgnt", dsp_grant, 1);
        pulses = 0;
        for (int i = 0; i < 99; i++) begin
            tick(1);
            pulses += int'(timeout);
        end
        check("to_early_pulse", pulses, 0);
        check("to_still_gnt", dsp_grant, 1);
        tick(1);
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
        check("to_pulse", timeout, 1);
        check("to_dgnt_drop", dsp_grant, 0);
        check("to_cs_hi", flash_cs_INV, 1);
        tick(1);
        check("to_pulse_end", timeout, 0);
        tick(20);
        check("to_no_regrant", dsp_grant, 0);
        dsp_cs_INV = 1'b1;
        tick(4);
        dsp_cs_INV = 1'b0;
        tick(3);
        check("to_regrant", dsp_grant, 1);
`else
        check("nto_pulse", timeout, 0);
        check("nto_hold", dsp_grant, 1);
        check("nto_cs", flash_cs_INV, 0);
`endif
        dsp_cs_INV = 1'b1;
        tick(10);
        check("end_idle", flash_cs_INV, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
